// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory-port arbiter: bus widths, bus command
// encodings, FSM state encoding, owner encoding and the starvation-counter
// update helper.
package mem_port_arb_pkg;

  localparam int CPU_ADDR_WIDTH = 32;
  localparam int CPU_DATA_WIDTH = 32;

  localparam logic [1:0] CPU_BUS_CMD_IDLE  = 2'b00;
  localparam logic [1:0] CPU_BUS_CMD_READ  = 2'b01;
  localparam logic [1:0] CPU_BUS_CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_LSU   = 1'b1;

  // Next starvation count: a fetch grant clears it, an LSU grant that
  // overtakes a waiting fetch bumps it (saturating at the limit).
  function automatic logic [3:0] starve_next(
    input logic [3:0] cnt,
    input logic [3:0] limit,
    input logic       lsu_grant,
    input logic       fetch_grant,
    input logic       f_req
  );
    logic [3:0] nxt;
    nxt = cnt;
    if (fetch_grant) begin
      nxt = 4'd0;
    end else if (lsu_grant && f_req && (cnt < limit)) begin
      nxt = cnt + 4'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares the single system-bus master port between
// instruction fetch and the LSU. One transaction in flight; LSU has
// priority, but after FETCH_STARVE_LIMIT consecutive LSU wins over a
// waiting fetch, fetch is forced through.
// Ports:
//   clk, nrst                      clock, async active-low reset
//   i_f_req/i_f_addr               fetch read request
//   o_f_ack/o_f_data/o_f_err       fetch completion (1-cycle pulse)
//   i_l_req/i_l_rnw/i_l_addr/
//   i_l_wdata/i_l_be               LSU request
//   o_l_ack/o_l_rdata/o_l_err      LSU completion (1-cycle pulse)
//   o_bus_cmd/addr/wdata/be        bus command phase (registered)
//   i_bus_cmd_ack                  slave accepted command
//   i_bus_rvalid/i_bus_rdata       read response
//   i_bus_err                      error, qualifies cmd_ack (wr) / rvalid (rd)
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      i_f_req,
  input  logic [CPU_ADDR_WIDTH-1:0] i_f_addr,
  output logic                      o_f_ack,
  output logic [CPU_DATA_WIDTH-1:0] o_f_data,
  output logic                      o_f_err,
  input  logic                      i_l_req,
  input  logic                      i_l_rnw,
  input  logic [CPU_ADDR_WIDTH-1:0] i_l_addr,
  input  logic [CPU_DATA_WIDTH-1:0] i_l_wdata,
  input  logic [3:0]                i_l_be,
  output logic                      o_l_ack,
  output logic [CPU_DATA_WIDTH-1:0] o_l_rdata,
  output logic                      o_l_err,
  output logic [1:0]                o_bus_cmd,
  output logic [CPU_ADDR_WIDTH-1:0] o_bus_addr,
  output logic [CPU_DATA_WIDTH-1:0] o_bus_wdata,
  output logic [3:0]                o_bus_be,
  input  logic                      i_bus_cmd_ack,
  input  logic                      i_bus_rvalid,
  input  logic [CPU_DATA_WIDTH-1:0] i_bus_rdata,
  input  logic                      i_bus_err
);

  localparam logic [3:0] STARVE_LIMIT = 4'(FETCH_STARVE_LIMIT);

  arb_state_e                state_r;
  arb_state_e                state_s;
  logic                      owner_r;
  logic [3:0]                starve_cnt_r;
  logic                      grant_f_s;
  logic                      grant_l_s;
  logic                      done_s;

  logic [1:0]                bus_cmd_r;
  logic [CPU_ADDR_WIDTH-1:0] bus_addr_r;
  logic [CPU_DATA_WIDTH-1:0] bus_wdata_r;
  logic [3:0]                bus_be_r;
  logic                      f_ack_r;
  logic [CPU_DATA_WIDTH-1:0] f_data_r;
  logic                      f_err_r;
  logic                      l_ack_r;
  logic [CPU_DATA_WIDTH-1:0] l_rdata_r;
  logic                      l_err_r;

  // Next-state, arbitration and completion decode.
  always_comb begin
    state_s   = state_r;
    grant_f_s = 1'b0;
    grant_l_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // LSU wins unless a waiting fetch has hit the starvation limit.
        if (i_l_req && !(i_f_req && (starve_cnt_r == STARVE_LIMIT))) begin
          grant_l_s = 1'b1;
          state_s   = ST_CMD;
        end else if (i_f_req) begin
          grant_f_s = 1'b1;
          state_s   = ST_CMD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (i_bus_cmd_ack) begin
          if (bus_cmd_r == CPU_BUS_CMD_WRITE) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_RESP: begin
        if (i_bus_rvalid) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and fetch-starvation counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_next(starve_cnt_r, STARVE_LIMIT, grant_l_s,
                                  grant_f_s, i_f_req);
    end
  end

  // Command capture on grant, bus command drop on accept, and the
  // registered completion pulse/data returned to the owner.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner_r     <= OWNER_FETCH;
      bus_cmd_r   <= CPU_BUS_CMD_IDLE;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      bus_be_r    <= 4'h0;
      f_ack_r     <= 1'b0;
      f_data_r    <= '0;
      f_err_r     <= 1'b0;
      l_ack_r     <= 1'b0;
      l_rdata_r   <= '0;
      l_err_r     <= 1'b0;
    end else begin
      f_ack_r <= 1'b0;
      l_ack_r <= 1'b0;
      if (grant_l_s) begin
        owner_r     <= OWNER_LSU;
        bus_cmd_r   <= i_l_rnw ? CPU_BUS_CMD_READ : CPU_BUS_CMD_WRITE;
        bus_addr_r  <= i_l_addr;
        bus_wdata_r <= i_l_wdata;
        bus_be_r    <= i_l_be;
      end else if (grant_f_s) begin
        owner_r     <= OWNER_FETCH;
        bus_cmd_r   <= CPU_BUS_CMD_READ;
        bus_addr_r  <= i_f_addr;
        bus_wdata_r <= '0;
        bus_be_r    <= 4'hF;
      end else if ((state_r == ST_CMD) && i_bus_cmd_ack) begin
        bus_cmd_r <= CPU_BUS_CMD_IDLE;
      end
      if (done_s) begin
        if (owner_r == OWNER_LSU) begin
          l_ack_r <= 1'b1;
          l_err_r <= i_bus_err;
          // Writes complete from CMD and leave the read data untouched.
          if (state_r == ST_RESP) begin
            l_rdata_r <= i_bus_rdata;
          end
        end else begin
          f_ack_r  <= 1'b1;
          f_err_r  <= i_bus_err;
          f_data_r <= i_bus_rdata;
        end
      end
    end
  end

  assign o_f_ack     = f_ack_r;
  assign o_f_data    = f_data_r;
  assign o_f_err     = f_err_r;
  assign o_l_ack     = l_ack_r;
  assign o_l_rdata   = l_rdata_r;
  assign o_l_err     = l_err_r;
  assign o_bus_cmd   = bus_cmd_r;
  assign o_bus_addr  = bus_addr_r;
  assign o_bus_wdata = bus_wdata_r;
  assign o_bus_be    = bus_be_r;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb. Inputs change 1ns after
// the rising edge; outputs are checked at that same point, well away from
// the edge at which they update.
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;

  logic        clk;
  logic        nrst;
  logic        i_f_req;
  logic [31:0] i_f_addr;
  logic        o_f_ack;
  logic [31:0] o_f_data;
  logic        o_f_err;
  logic        i_l_req;
  logic        i_l_rnw;
  logic [31:0] i_l_addr;
  logic [31:0] i_l_wdata;
  logic [3:0]  i_l_be;
  logic        o_l_ack;
  logic [31:0] o_l_rdata;
  logic        o_l_err;
  logic [1:0]  o_bus_cmd;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_cmd_ack;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic        i_bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arb #(.FETCH_STARVE_LIMIT(4)) dut (
    .clk(clk), .nrst(nrst),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr),
    .o_f_ack(o_f_ack), .o_f_data(o_f_data), .o_f_err(o_f_err),
    .i_l_req(i_l_req), .i_l_rnw(i_l_rnw), .i_l_addr(i_l_addr),
    .i_l_wdata(i_l_wdata), .i_l_be(i_l_be),
    .o_l_ack(o_l_ack), .o_l_rdata(o_l_rdata), .o_l_err(o_l_err),
    .o_bus_cmd(o_bus_cmd), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_cmd_ack(i_bus_cmd_ack), .i_bus_rvalid(i_bus_rvalid),
    .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_lsu [10];
    logic is_lsu;
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    nrst = 1'b0;
    i_f_req = 1'b0; i_f_addr = 32'h0;
    i_l_req = 1'b0; i_l_rnw = 1'b0; i_l_addr = 32'h0; i_l_wdata = 32'h0; i_l_be = 4'h0;
    i_bus_cmd_ack = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0; i_bus_err = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_bus_cmd", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("rst_bus_addr", o_bus_addr, 32'h0);
    check("rst_bus_be", 32'(o_bus_be), 32'h0);
    check("rst_f_ack", 32'(o_f_ack), 32'h0);
    check("rst_l_ack", 32'(o_l_ack), 32'h0);
    check("rst_f_data", o_f_data, 32'h0);
    nrst = 1'b1;
    tick();

    // 1: fetch-only read, zero wait
    i_f_req = 1'b1; i_f_addr = 32'h0000_0100;
    tick();
    check("t1_cmd_read", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_READ));
    check("t1_addr", o_bus_addr, 32'h0000_0100);
    check("t1_be", 32'(o_bus_be), 32'hF);
    i_bus_cmd_ack = 1'b1;
    tick();
    check("t1_resp_cmd_idle", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("t1_no_early_ack", 32'(o_f_ack), 32'h0);
    i_bus_cmd_ack = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
    tick();
    check("t1_f_ack", 32'(o_f_ack), 32'h1);
    check("t1_f_data", o_f_data, 32'hDEAD_BEEF);
    check("t1_f_err", 32'(o_f_err), 32'h0);
    check("t1_l_ack", 32'(o_l_ack), 32'h0);
    i_bus_rvalid = 1'b0; i_f_req = 1'b0;
    tick();
    check("t1_ack_pulse", 32'(o_f_ack), 32'h0);
    check("t1_idle", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));

    // 2: LSU write with 3 stall cycles
    i_l_req = 1'b1; i_l_rnw = 1'b0; i_l_addr = 32'h10; i_l_wdata = 32'h1234_5678; i_l_be = 4'b0011;
    tick();
    check("t2_cmd_write", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_WRITE));
    check("t2_addr", o_bus_addr, 32'h10);
    check("t2_wdata", o_bus_wdata, 32'h1234_5678);
    check("t2_be", 32'(o_bus_be), 32'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_cmd", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_WRITE));
      check("t2_stall_addr", o_bus_addr, 32'h10);
      check("t2_stall_wdata", o_bus_wdata, 32'h1234_5678);
      check("t2_stall_be", 32'(o_bus_be), 32'h3);
      check("t2_stall_l_ack", 32'(o_l_ack), 32'h0);
      check("t2_stall_f_ack", 32'(o_f_ack), 32'h0);
    end
    i_bus_cmd_ack = 1'b1;
    tick();
    check("t2_l_ack", 32'(o_l_ack), 32'h1);
    check("t2_l_err", 32'(o_l_err), 32'h0);
    check("t2_l_rdata_kept", o_l_rdata, 32'h0);
    check("t2_f_ack", 32'(o_f_ack), 32'h0);
    i_bus_cmd_ack = 1'b0; i_l_req = 1'b0;
    tick();
    check("t2_ack_pulse", 32'(o_l_ack), 32'h0);

    // 3: both requesting continuously, limit 4
    i_l_req = 1'b1; i_l_rnw = 1'b0; i_l_addr = 32'h20; i_l_wdata = 32'h5555_0000; i_l_be = 4'hF;
    i_f_req = 1'b1; i_f_addr = 32'h40;
    for (int g = 0; g < 10; g++) begin
      tick();
      is_lsu = (o_bus_addr == 32'h20);
      check("t3_grant_owner", 32'(is_lsu), 32'(exp_lsu[g]));
      if (!exp_lsu[g]) begin
        check("t3_starve_clr", 32'(dut.starve_cnt_r), 32'h0);
      end
      i_bus_cmd_ack = 1'b1;
      tick();
      i_bus_cmd_ack = 1'b0;
      if (!is_lsu) begin
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'(g);
        tick();
        i_bus_rvalid = 1'b0;
        check("t3_f_ack", 32'(o_f_ack), 32'h1);
        check("t3_f_data", o_f_data, 32'(g));
      end else begin
        check("t3_l_ack", 32'(o_l_ack), 32'h1);
        check("t3_l_no_f_ack", 32'(o_f_ack), 32'h0);
      end
    end
    i_l_req = 1'b0; i_f_req = 1'b0;
    tick();
    check("t3_idle_after", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("t3_starve_zero", 32'(dut.starve_cnt_r), 32'h0);

    // 4: LSU read with bus error, then a clean write
    i_l_req = 1'b1; i_l_rnw = 1'b1; i_l_addr = 32'h80;
    tick();
    check("t4_cmd_read", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_READ));
    i_bus_cmd_ack = 1'b1;
    tick();
    i_bus_cmd_ack = 1'b0;
    tick();
    check("t4_wait_cmd_idle", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("t4_wait_no_ack", 32'(o_l_ack), 32'h0);
    i_bus_rvalid = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'hCAFE_0001;
    tick();
    check("t4_l_ack", 32'(o_l_ack), 32'h1);
    check("t4_l_err", 32'(o_l_err), 32'h1);
    check("t4_l_rdata", o_l_rdata, 32'hCAFE_0001);
    i_l_req = 1'b0; i_bus_rvalid = 1'b0; i_bus_err = 1'b0;
    tick();
    i_l_req = 1'b1; i_l_rnw = 1'b0; i_l_addr = 32'h84; i_l_wdata = 32'h0; i_l_be = 4'h1;
    tick();
    i_bus_cmd_ack = 1'b1;
    tick();
    check("t4_next_ack", 32'(o_l_ack), 32'h1);
    check("t4_next_err", 32'(o_l_err), 32'h0);
    i_bus_cmd_ack = 1'b0; i_l_req = 1'b0;
    tick();

    // 5: reset pulsed while in RESP
    i_f_req = 1'b1; i_f_addr = 32'h300;
    tick();
    i_bus_cmd_ack = 1'b1;
    tick();
    i_bus_cmd_ack = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    check("t5_async_cmd", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("t5_async_addr", o_bus_addr, 32'h0);
    check("t5_async_f_data", o_f_data, 32'h0);
    check("t5_async_l_rdata", o_l_rdata, 32'h0);
    check("t5_async_be", 32'(o_bus_be), 32'h0);
    i_f_req = 1'b0;
    tick();
    check("t5_no_ack", 32'(o_f_ack), 32'h0);
    tick();
    nrst = 1'b1;
    tick();
    i_f_req = 1'b1; i_f_addr = 32'h200;
    tick();
    check("t5_fresh_cmd", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_READ));
    check("t5_fresh_addr", o_bus_addr, 32'h200);
    i_bus_cmd_ack = 1'b1;
    tick();
    i_bus_cmd_ack = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0BAD_F00D;
    tick();
    check("t5_fresh_ack", 32'(o_f_ack), 32'h1);
    check("t5_fresh_data", o_f_data, 32'h0BAD_F00D);
    i_bus_rvalid = 1'b0; i_f_req = 1'b0;
    tick();

    // 6: spurious bus strobes in IDLE; fetch request dropped before grant
    i_bus_rvalid = 1'b1; i_bus_cmd_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    tick();
    check("t6_spur_f_ack", 32'(o_f_ack), 32'h0);
    check("t6_spur_l_ack", 32'(o_l_ack), 32'h0);
    check("t6_spur_cmd", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("t6_spur_f_data", o_f_data, 32'h0BAD_F00D);
    i_bus_rvalid = 1'b0; i_bus_cmd_ack = 1'b0;
    i_l_req = 1'b1; i_l_rnw = 1'b0; i_l_addr = 32'h44; i_l_wdata = 32'h9; i_l_be = 4'hF;
    tick();
    i_f_req = 1'b1; i_f_addr = 32'h500;
    tick();
    i_f_req = 1'b0; i_bus_cmd_ack = 1'b1;
    tick();
    check("t6_l_ack", 32'(o_l_ack), 32'h1);
    i_l_req = 1'b0; i_bus_cmd_ack = 1'b0;
    tick();
    check("t6_no_fetch_grant", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));
    check("t6_starve_hold", 32'(dut.starve_cnt_r), 32'h0);
    tick();
    check("t6_no_f_ack", 32'(o_f_ack), 32'h0);
    check("t6_still_idle", 32'(o_bus_cmd), 32'(CPU_BUS_CMD_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
